rca_multiword_seq: RTL and testbench

// Sequencer that runs WORDS*16-bit add/subtract operations through one shared
// 16-bit ripple-carry adder, one 16-bit slice per cycle, LSB slice first.
// - Chains the carry between slices.
// - Valid/ready handshake on both the operand side and the result side.
// - Sits between the operand source and the combinational RCA_16_bit instance.

---
 rtl/rca_multiword_seq_if.sv | 32 +++
 rtl/rca_multiword_seq.sv | 123 ++++++++++++
 tb/tb_rca_multiword_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_multiword_seq_if.sv
// Operand, result and shared-adder signals of the multi-word add/sub sequencer.
// The sequencer sits on the slave side; the operand source, result consumer
// and the external 16-bit ripple-carry adder sit on the master side.
interface rca_multiword_seq_if #(
  parameter int WORDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  sub;
  logic [16*WORDS-1:0]   a;
  logic [16*WORDS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*WORDS-1:0]   sum;
  logic                  c_out;
  logic                  ovf;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic                  add_cin;
  logic [15:0]           add_s;
  logic                  add_cout;

  modport slave (
    input  in_valid, sub, a, b, out_ready, add_s, add_cout,
    output in_ready, out_valid, sum, c_out, ovf, add_a, add_b, add_cin
  );

  modport master (
    output in_valid, sub, a, b, out_ready, add_s, add_cout,
    input  in_ready, out_valid, sum, c_out, ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/rca_multiword_seq.sv
// Multi-word add/subtract sequencer: pushes a WORDS*16-bit operation through
// one external 16-bit ripple-carry adder, one slice per cycle, LSB slice
// first, chaining the carry between slices. Subtraction is a + ~b + 1.
module rca_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  rca_multiword_seq_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int OP_W   = DATA_W * WORDS;
  localparam int IDX_W  = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [OP_W-1:0]   a_p0;
  logic [OP_W-1:0]   b_p0;
  logic              carry_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [IDX_W+3:0]  base;
  logic              last_slice;
  logic              accept;

  logic [OP_W-1:0]   sum_r;
  logic              c_out_r;
  logic              ovf_r;

  // Signed overflow of the top slice: equal operand signs, different result sign.
  function automatic logic ovf_detect(input logic signed [DATA_W-1:0] a_top,
                                      input logic signed [DATA_W-1:0] b_top,
                                      input logic signed [DATA_W-1:0] s_top);
    return ((a_top < 0) == (b_top < 0)) && ((s_top < 0) != (a_top < 0));
  endfunction

  assign base       = {idx_p0, 4'b0000};
  assign last_slice = (idx_p0 == LAST_IDX);
  assign accept     = (state == IDLE) && bus.in_valid;

  assign bus.sum    = sum_r;
  assign bus.c_out  = c_out_r;
  assign bus.ovf    = ovf_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and adder drive; adder inputs idle at zero.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.add_a   = a_p0[base +: DATA_W];
        bus.add_b   = b_p0[base +: DATA_W];
        bus.add_cin = carry_p0;
        if (last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch on accept (b pre-inverted for subtract); carry chained per slice.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0     <= bus.a;
      b_p0     <= bus.sub ? ~bus.b : bus.b;
      carry_p0 <= bus.sub;
    end else if (state == RUN) begin
      carry_p0 <= bus.add_cout;
    end
  end

  // Slice index and result registers; result held untouched through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p0  <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      idx_p0 <= '0;
    end else if (state == RUN) begin
      sum_r[base +: DATA_W] <= bus.add_s;
      if (last_slice) begin
        idx_p0  <= '0;
        c_out_r <= bus.add_cout;
        ovf_r   <= ovf_detect($signed(bus.add_a), $signed(bus.add_b), $signed(bus.add_s));
      end else begin
        idx_p0 <= idx_p0 + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rca_multiword_seq.sv
// Bench for rca_multiword_seq: external 16-bit RCA model, a whole-operation
// reference model with a per-cycle compare process, and directed tests.
module tb_rca_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rca_multiword_seq_if #(.WORDS(WORDS)) bus ();

  rca_multiword_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Combinational 16-bit ripple-carry adder living outside the sequencer.
  assign {bus.add_cout, bus.add_s} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Whole-word reference: unsigned carry / no-borrow and signed range overflow.
  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t r;
    logic signed [W:0] sr;
    if (!s) begin
      {r.c, r.sum} = {1'b0, a} + {1'b0, b};
      sr = $signed({a[W-1], a}) + $signed({b[W-1], b});
    end else begin
      r.sum = a - b;
      r.c   = (a >= b);
      sr = $signed({a[W-1], a}) - $signed({b[W-1], b});
    end
    r.o = (sr[W] != sr[W-1]);
    return r;
  endfunction

  // Model state: ready flag, cycles left until the result, result pending.
  logic         m_ready = 1'b1;
  int           m_cnt   = 0;
  logic         m_valid = 1'b0;
  res_t         m_res;
  logic [W-1:0] m_a;
  logic [W-1:0] m_bx;
  int           m_cyc   = 0;
  int           hs_cnt  = 0;
  int           acc_q[$];
  logic         chk_en  = 1'b0;

  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    if (bus.out_valid && bus.out_ready && !rst) hs_cnt <= hs_cnt + 1;
    if (rst) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_valid <= 1'b0;
    end else if (m_ready && bus.in_valid) begin
      m_res   <= ref_op(bus.a, bus.b, bus.sub);
      m_a     <= bus.a;
      m_bx    <= bus.sub ? ~bus.b : bus.b;
      m_ready <= 1'b0;
      m_cnt   <= WORDS;
      acc_q.push_back(m_cyc);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (m_valid && bus.out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int k;
    if (chk_en) begin
      check("in_ready", W'(bus.in_ready), W'(m_ready));
      check("out_valid", W'(bus.out_valid), W'(m_valid));
      if (m_valid) begin
        check("sum", bus.sum, m_res.sum);
        check("c_out", W'(bus.c_out), W'(m_res.c));
        check("ovf", W'(bus.ovf), W'(m_res.o));
      end
      if (m_cnt > 0) begin
        k = WORDS - m_cnt;
        check("add_a slice", W'(bus.add_a), W'(m_a[16*k +: 16]));
        check("add_b slice", W'(bus.add_b), W'(m_bx[16*k +: 16]));
      end else begin
        check("add_a idle", W'(bus.add_a), W'(0));
        check("add_b idle", W'(bus.add_b), W'(0));
        check("add_cin idle", W'(bus.add_cin), W'(0));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("accept timeout", W'(0), W'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({name, " result timeout"}, W'(0), W'(1));
    else if (exp_lat > 0) check({name, " latency"}, W'((m_cyc - 1) - acc_q[$]), W'(exp_lat));
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    start_op(a, b, s);
    wait_result(name, WORDS);
    check({name, " sum"}, bus.sum, es);
    check({name, " c_out"}, W'(bus.c_out), W'(ec));
    check({name, " ovf"}, W'(bus.ovf), W'(eo));
    check({name, " model sum"}, m_res.sum, es);
    check({name, " model c"}, W'(m_res.c), W'(ec));
    check({name, " model ovf"}, W'(m_res.o), W'(eo));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s0;
    int hs0;
    int base;
    bus.in_valid  = 1'b0;
    bus.sub       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset in_ready", W'(bus.in_ready), W'(1));
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset sum", bus.sum, W'(0));
    check("reset c_out", W'(bus.c_out), W'(0));
    check("reset ovf", W'(bus.ovf), W'(0));
    check("reset add_a", W'(bus.add_a), W'(0));

    // Carry ripple through every slice, borrow, signed overflow.
    do_op("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    do_op("t2", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_op("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("t3b", 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b1,
          64'h0000_0000_0000_FFFF, 1'b1, 1'b0);

    // Backpressure: result held for 5 cycles, then exactly one handshake.
    bus.out_ready = 1'b0;
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_result("t4", WORDS);
    check("t4 sum", bus.sum, 64'h0);
    check("t4 c_out", W'(bus.c_out), W'(1));
    check("t4 ovf", W'(bus.ovf), W'(1));
    s0 = bus.sum;
    hs0 = hs_cnt;
    repeat (5) begin
      @(negedge clk);
      check("t4 hold valid", W'(bus.out_valid), W'(1));
      check("t4 hold in_ready", W'(bus.in_ready), W'(0));
      check("t4 hold sum", bus.sum, s0);
      check("t4 hold c_out", W'(bus.c_out), W'(1));
      check("t4 hold ovf", W'(bus.ovf), W'(1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4 released valid", W'(bus.out_valid), W'(0));
    @(negedge clk);
    check("t4 one handshake", W'(hs_cnt), W'(hs0 + 1));

    // Reset during the second RUN cycle aborts the operation.
    hs0 = hs_cnt;
    start_op(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5 in_ready", W'(bus.in_ready), W'(1));
    check("t5 out_valid", W'(bus.out_valid), W'(0));
    check("t5 add_a", W'(bus.add_a), W'(0));
    check("t5 add_b", W'(bus.add_b), W'(0));
    check("t5 add_cin", W'(bus.add_cin), W'(0));
    repeat (WORDS + 2) @(negedge clk);
    check("t5 no result", W'(hs_cnt), W'(hs0));
    do_op("t5 after", 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0);

    // Back-to-back random operations with the consumer always ready.
    hs0 = hs_cnt;
    base = acc_q.size();
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.sub = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 50) check("t6 accept timeout", W'(0), W'(1));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_result("t6", 0);
    repeat (2) @(negedge clk);
    check("t6 accepts", W'(acc_q.size() - base), W'(10));
    for (int i = 1; i < 10; i++) begin
      if (base + i < acc_q.size())
        check("t6 spacing", W'(acc_q[base+i] - acc_q[base+i-1]), W'(WORDS + 2));
    end
    check("t6 results", W'(hs_cnt - hs0), W'(10));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
